// File: rtl/crc_frame_engine_pkg.sv
// Shared types for the CRC frame engine.
//   crc_state_t : engine FSM states (idle, running through bytes, publishing result)
//   crc_mode_t  : generate (report CRC) or check (compare against expected CRC)
package crc_frame_engine_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} crc_state_t;

    typedef enum logic {CRC_GEN, CRC_CHECK} crc_mode_t;

    // Byte index counter width; one spare bit so N_BYTES = 1 still gets a real vector.
    function automatic int unsigned idx_width(input int unsigned n_bytes);
        return $clog2(n_bytes) + 1;
    endfunction

endpackage

// File: rtl/crc_frame_engine_if.sv
// Request/result bundle between frame-assembly logic (master) and the CRC engine (slave).
//   start, mode, bytes_flat, crc_expected, abort : request side, driven by master
//   busy, done, aborted, crc_out, crc_ok         : status/result side, driven by engine
interface crc_frame_engine_if #(
    parameter int unsigned N_BYTES = 6,
    parameter int unsigned CRC_W   = 8
);

    logic                   start;
    logic                   mode;
    logic [8*N_BYTES-1:0]   bytes_flat;
    logic [CRC_W-1:0]       crc_expected;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [CRC_W-1:0]       crc_out;
    logic                   crc_ok;

    modport master (
        output start,
        output mode,
        output bytes_flat,
        output crc_expected,
        output abort,
        input  busy,
        input  done,
        input  aborted,
        input  crc_out,
        input  crc_ok
    );

    modport slave (
        input  start,
        input  mode,
        input  bytes_flat,
        input  crc_expected,
        input  abort,
        output busy,
        output done,
        output aborted,
        output crc_out,
        output crc_ok
    );

endinterface

// File: rtl/crc_frame_engine_byte_step.sv
// Combinational CRC update for one byte: MSB-first, non-reflected, eight unrolled bit steps.
//   crc_in   : current CRC register
//   byte_in  : data byte, bit 7 consumed first
//   crc_next : CRC register after the byte
module crc_frame_engine_byte_step #(
    parameter int unsigned       CRC_W = 8,
    parameter logic [CRC_W-1:0]  POLY  = CRC_W'(8'h07)
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       byte_in,
    output logic [CRC_W-1:0] crc_next
);

    logic [CRC_W-1:0] acc;

    always_comb begin
        acc = crc_in;
        for (int i = 7; i >= 0; i--) begin
            // Feedback is the outgoing MSB XOR the incoming data bit.
            if (acc[CRC_W-1] ^ byte_in[i]) begin
                acc = {acc[CRC_W-2:0], 1'b0} ^ POLY;
            end else begin
                acc = {acc[CRC_W-2:0], 1'b0};
            end
        end
    end

    assign crc_next = acc;

endmodule

// File: rtl/crc_frame_engine.sv
// Fixed-length frame CRC engine with generate and check modes.
// A start in idle snapshots the frame, mode and expected CRC, then one byte is folded in per
// cycle; a final cycle publishes crc_out/crc_ok and pulses done. Abort cancels a busy operation
// and pulses aborted while leaving the previous result untouched.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : request/result bundle (slave side), see crc_frame_engine_if
module crc_frame_engine
    import crc_frame_engine_pkg::*;
#(
    parameter int unsigned       N_BYTES = 6,
    parameter int unsigned       CRC_W   = 8,
    parameter logic [CRC_W-1:0]  POLY    = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0]  INIT    = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              rst,
    crc_frame_engine_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_width(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    crc_state_t           state_q;
    logic [8*N_BYTES-1:0] snap_bytes_q;
    crc_mode_t            snap_mode_q;
    logic [CRC_W-1:0]     snap_expected_q;
    logic [CRC_W-1:0]     crc_reg_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 done_q;
    logic                 aborted_q;
    logic [CRC_W-1:0]     crc_out_q;
    logic                 crc_ok_q;

    logic [7:0]           cur_byte;
    logic [CRC_W-1:0]     crc_next;
    logic [CRC_W-1:0]     crc_final;

    // Byte mux over the snapshot; idx only ranges over valid bytes while running.
    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < N_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_byte = snap_bytes_q[8*k +: 8];
            end
        end
    end

    crc_frame_engine_byte_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_byte_step (
        .crc_in   (crc_reg_q),
        .byte_in  (cur_byte),
        .crc_next (crc_next)
    );

    assign crc_final = crc_reg_q ^ XOR_OUT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            snap_bytes_q    <= '0;
            snap_mode_q     <= CRC_GEN;
            snap_expected_q <= '0;
            crc_reg_q       <= '0;
            idx_q           <= '0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            crc_out_q       <= '0;
            crc_ok_q        <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // Abort in idle only suppresses a simultaneous start.
                    if (bus.start && !bus.abort) begin
                        snap_bytes_q    <= bus.bytes_flat;
                        snap_mode_q     <= crc_mode_t'(bus.mode);
                        snap_expected_q <= bus.crc_expected;
                        crc_reg_q       <= INIT;
                        idx_q           <= '0;
                        state_q         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        crc_reg_q <= crc_next;
                        idx_q     <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                    end else begin
                        crc_out_q <= crc_final;
                        crc_ok_q  <= (snap_mode_q == CRC_CHECK) && (crc_final == snap_expected_q);
                        done_q    <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.crc_out = crc_out_q;
    assign bus.crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Self-checking bench for crc_frame_engine: a default-parameter instance driven with random
// frames against a polynomial long-division model, plus two 9-byte instances (CRC-8 and
// CRC-16/CCITT-FALSE) checked against the "123456789" check values.
module tb_crc_frame_engine;

    localparam int unsigned NB     = 6;
    localparam logic [71:0] FRAME9 = 72'h39_38_37_36_35_34_33_32_31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    crc_frame_engine_if #(.N_BYTES(NB), .CRC_W(8))  bus_a ();
    crc_frame_engine_if #(.N_BYTES(9),  .CRC_W(8))  bus_b ();
    crc_frame_engine_if #(.N_BYTES(9),  .CRC_W(16)) bus_c ();

    crc_frame_engine #(
        .N_BYTES(NB), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    crc_frame_engine #(
        .N_BYTES(9), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    crc_frame_engine #(
        .N_BYTES(9), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)
    ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // CRC-8/0x07, init 0: remainder of M(x)*x^8 divided by x^8+x^2+x+1, byte 0 most significant.
    function automatic logic [7:0] ref_crc(input logic [8*NB-1:0] fr);
        logic [63:0] m;
        m = 64'd0;
        for (int k = 0; k < int'(NB); k++) m = (m << 8) | 64'(fr[8*k +: 8]);
        m = m << 8;
        for (int b = 63; b >= 8; b--) begin
            if (m[b]) m = m ^ (64'h107 << (b - 8));
        end
        return m[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on dut_a. Inputs are scrambled two cycles in to prove the snapshot; with
    // hold_start the start line stays high while busy. Returns at the done sample.
    task automatic run_a(input logic [8*NB-1:0] fr, input logic m, input logic [7:0] ex,
                         input logic [8*NB-1:0] fr_mid, input logic hold_start,
                         output int lat, output int busy_cnt);
        bus_a.bytes_flat   = fr;
        bus_a.mode         = m;
        bus_a.crc_expected = ex;
        bus_a.start        = 1'b1;
        tick();
        bus_a.start = hold_start;
        lat      = 0;
        busy_cnt = 0;
        while (!bus_a.done && lat < 30) begin
            if (lat == 2) begin
                bus_a.bytes_flat   = fr_mid;
                bus_a.mode         = ~m;
                bus_a.crc_expected = ~ex;
            end
            if (lat == int'(NB)) bus_a.start = 1'b0;
            if (bus_a.busy) busy_cnt++;
            tick();
            lat++;
        end
        bus_a.start = 1'b0;
    endtask

    task automatic run_c(input logic m, input logic [15:0] ex, output int lat);
        bus_c.bytes_flat   = FRAME9;
        bus_c.mode         = m;
        bus_c.crc_expected = ex;
        bus_c.start        = 1'b1;
        tick();
        bus_c.start = 1'b0;
        lat = 0;
        while (!bus_c.done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [8*NB-1:0] fr;
        logic [8*NB-1:0] fr2;
        logic            m;
        logic [7:0]      ex;
        logic [7:0]      exp_crc;
        logic [7:0]      prior;
        int              lat;
        int              bc;
        int              n_done;
        int              n_ab;

        bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.bytes_flat = '0;
        bus_a.crc_expected = '0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.bytes_flat = '0;
        bus_b.crc_expected = '0; bus_b.abort = 1'b0;
        bus_c.start = 1'b0; bus_c.mode = 1'b0; bus_c.bytes_flat = '0;
        bus_c.crc_expected = '0; bus_c.abort = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(bus_a.busy), 32'd0);
        check("reset_done", 32'(bus_a.done), 32'd0);
        check("reset_aborted", 32'(bus_a.aborted), 32'd0);
        check("reset_crc_out", 32'(bus_a.crc_out), 32'd0);
        check("reset_crc_ok", 32'(bus_a.crc_ok), 32'd0);

        // "123456789" on the 9-byte CRC-8 and CRC-16 instances together
        bus_b.bytes_flat = FRAME9;
        bus_b.start      = 1'b1;
        bus_c.bytes_flat = FRAME9;
        bus_c.start      = 1'b1;
        tick();
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        lat = 0;
        while (!bus_b.done && lat < 40) begin
            tick();
            lat++;
        end
        check("crc8_latency", 32'(lat), 32'd10);
        check("crc8_value", 32'(bus_b.crc_out), 32'hF4);
        check("crc8_ok_gen", 32'(bus_b.crc_ok), 32'd0);
        check("crc16_done", 32'(bus_c.done), 32'd1);
        check("crc16_value", 32'(bus_c.crc_out), 32'h29B1);
        run_c(1'b1, 16'h29B1, lat);
        check("crc16_chk_latency", 32'(lat), 32'd10);
        check("crc16_chk_match", 32'(bus_c.crc_ok), 32'd1);
        run_c(1'b1, 16'h29B0, lat);
        check("crc16_chk_miss", 32'(bus_c.crc_ok), 32'd0);
        check("crc16_chk_miss_value", 32'(bus_c.crc_out), 32'h29B1);

        // All-zero frame, scrambled to all-ones mid-frame
        run_a('0, 1'b0, 8'h00, {NB{8'hFF}}, 1'b0, lat, bc);
        check("zero_latency", 32'(lat), 32'd7);
        check("zero_busy_cycles", 32'(bc), 32'd7);
        check("zero_busy_on_done", 32'(bus_a.busy), 32'd0);
        check("zero_crc", 32'(bus_a.crc_out), 32'h00);
        check("zero_ok", 32'(bus_a.crc_ok), 32'd0);

        // Random frames, back-to-back (each start issued on the previous done cycle)
        for (int f = 0; f < 10; f++) begin
            fr      = {16'($urandom), $urandom};
            fr2     = {16'($urandom), $urandom};
            m       = 1'($urandom_range(0, 1));
            exp_crc = ref_crc(fr);
            ex      = ($urandom_range(0, 1) == 1) ? exp_crc : 8'($urandom);
            run_a(fr, m, ex, fr2, 1'b0, lat, bc);
            check("rand_latency", 32'(lat), 32'd7);
            check("rand_crc", 32'(bus_a.crc_out), 32'(exp_crc));
            check("rand_ok", 32'(bus_a.crc_ok), 32'(m && (ex == exp_crc)));
        end

        // Start held high through busy: one done, no queued frame
        fr = {16'($urandom), $urandom};
        run_a(fr, 1'b0, 8'h00, {16'($urandom), $urandom}, 1'b1, lat, bc);
        check("held_start_latency", 32'(lat), 32'd7);
        check("held_start_crc", 32'(bus_a.crc_out), 32'(ref_crc(fr)));
        n_done = 0;
        repeat (15) begin
            tick();
            if (bus_a.done) n_done++;
        end
        check("held_start_extra_done", 32'(n_done), 32'd0);
        check("held_start_idle", 32'(bus_a.busy), 32'd0);

        // Abort on the third RUN cycle
        fr = {16'($urandom), $urandom};
        run_a(fr, 1'b0, 8'h00, fr, 1'b0, lat, bc);
        prior = ref_crc(fr);
        check("pre_abort_crc", 32'(bus_a.crc_out), 32'(prior));
        bus_a.bytes_flat = {16'($urandom), $urandom};
        bus_a.mode       = 1'b1;
        bus_a.start      = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check("abort_pulse", 32'(bus_a.aborted), 32'd1);
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        check("abort_no_done", 32'(bus_a.done), 32'd0);
        n_done = 0;
        n_ab   = 0;
        repeat (12) begin
            tick();
            if (bus_a.done) n_done++;
            if (bus_a.aborted) n_ab++;
        end
        check("abort_later_done", 32'(n_done), 32'd0);
        check("abort_pulse_width", 32'(n_ab), 32'd0);
        check("abort_crc_kept", 32'(bus_a.crc_out), 32'(prior));

        // Abort together with start while idle
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        check("idle_abort_busy", 32'(bus_a.busy), 32'd0);
        check("idle_abort_pulse", 32'(bus_a.aborted), 32'd0);
        n_done = 0;
        repeat (10) begin
            tick();
            if (bus_a.done || bus_a.busy) n_done++;
        end
        check("idle_abort_activity", 32'(n_done), 32'd0);

        // Asynchronous reset mid-frame
        fr      = {16'($urandom), $urandom};
        exp_crc = ref_crc(fr);
        run_a(fr, 1'b1, exp_crc, fr, 1'b0, lat, bc);
        check("pre_reset_ok", 32'(bus_a.crc_ok), 32'd1);
        bus_a.bytes_flat = {16'($urandom), $urandom};
        bus_a.start      = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus_a.busy), 32'd0);
        check("async_rst_done", 32'(bus_a.done), 32'd0);
        check("async_rst_crc_out", 32'(bus_a.crc_out), 32'd0);
        check("async_rst_crc_ok", 32'(bus_a.crc_ok), 32'd0);
        tick();
        rst = 1'b0;
        fr = {16'($urandom), $urandom};
        run_a(fr, 1'b0, 8'h00, fr, 1'b0, lat, bc);
        check("post_rst_latency", 32'(lat), 32'd7);
        check("post_rst_crc", 32'(bus_a.crc_out), 32'(ref_crc(fr)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
